seq_shift_unit: RTL and testbench

- Parametrised, multi-cycle shift unit; successor to the fixed combinational shift-by-2 stage used in the shift-add multiplier datapath.
- Shifts a WIDTH-bit operand left or right by a run-time amount in logical, arithmetic or rotate mode, moving at most STEP bit positions per clock.
- Uses a start/busy/done handshake, so the multiplier controller can sequence partial-product shifts without a full barrel shifter.

---
 rtl/seq_shift_unit_pkg.sv | 21 ++
 rtl/seq_shift_step.sv | 47 ++++
 rtl/seq_shift_unit.sv | 140 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_unit_pkg.sv
// Shared encodings for the multi-cycle shift unit: modes, directions, FSM states.
// Optional overflow flag is enabled by defining SEQ_SHIFT_OVF_EN.
package seq_shift_unit_pkg;

   localparam logic [1:0] MODE_LOGIC = 2'b00;
   localparam logic [1:0] MODE_ARITH = 2'b01;
   localparam logic [1:0] MODE_ROT   = 2'b10;

   localparam logic DIR_L = 1'b0;
   localparam logic DIR_R = 1'b1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   typedef struct packed {
      logic       dir;
      logic [1:0] mode;
   } op_cfg_t;

endpackage

// File: rtl/seq_shift_step.sv
// Combinational single-step shifter: moves data by k (0..STEP) positions.
// With SEQ_SHIFT_OVF_EN it also reports the bits pushed out of the MSB end on a left shift.
module seq_shift_step
   import seq_shift_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 2,
   parameter int KW    = $clog2(STEP + 1)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [KW-1:0]    k_i,
   input  logic             dir_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] data_o
`ifdef SEQ_SHIFT_OVF_EN
   ,
   output logic [STEP-1:0]  out_bits_o
`endif
);

   int unsigned kk;

   always_comb begin
      kk     = 32'(k_i);
      data_o = data_i;
      if (mode_i == MODE_ROT) begin
         if (dir_i == DIR_L) data_o = (data_i << kk) | (data_i >> (WIDTH - kk));
         else                data_o = (data_i >> kk) | (data_i << (WIDTH - kk));
      end else if (dir_i == DIR_R && mode_i == MODE_ARITH) begin
         data_o = WIDTH'($signed(data_i) >>> kk);
      end else if (dir_i == DIR_R) begin
         data_o = data_i >> kk;
      end else begin
         data_o = data_i << kk;
      end
   end

`ifdef SEQ_SHIFT_OVF_EN
   // Low k bits of out_bits_o hold the bits leaving the top on a left shift.
   logic [WIDTH+STEP-1:0] wide;
   always_comb begin
      wide       = {{STEP{1'b0}}, data_i} << kk;
      out_bits_o = wide[WIDTH+STEP-1 -: STEP];
   end
`endif

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit (left/right, logical/arithmetic/rotate, STEP bits per clock)
// with start/busy/done handshake. Define SEQ_SHIFT_OVF_EN to add the sticky ovf output.
module seq_shift_unit
   import seq_shift_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 2,
   parameter int AW    = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    amount,
   input  logic             dir,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       state_o
`ifdef SEQ_SHIFT_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int KW = $clog2(STEP + 1);

   logic [1:0]       state_q, state_d;
   logic [AW-1:0]    rem_q, rem_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   op_cfg_t          cfg_q, cfg_d;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] step_data;
   logic [AW-1:0]    rot_amt;

`ifdef SEQ_SHIFT_OVF_EN
   logic            ovf_q, ovf_d;
   logic            sign_q, sign_d;
   logic [STEP-1:0] out_bits;
   logic [STEP-1:0] out_mask;
`endif

   seq_shift_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .KW    (KW)
   ) u_step (
      .data_i     (dout_q),
      .k_i        (k),
      .dir_i      (cfg_q.dir),
      .mode_i     (cfg_q.mode),
      .data_o     (step_data)
`ifdef SEQ_SHIFT_OVF_EN
      ,
      .out_bits_o (out_bits)
`endif
   );

   always_comb begin
      rot_amt = AW'(32'(amount) % WIDTH);
      if (32'(rem_q) >= STEP) k = KW'(STEP);
      else                    k = KW'(rem_q);
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dout_d  = dout_q;
      cfg_d   = cfg_q;
`ifdef SEQ_SHIFT_OVF_EN
      ovf_d    = ovf_q;
      sign_d   = sign_q;
      out_mask = ~({STEP{1'b1}} << k);
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dout_d  = din;
               cfg_d   = '{dir: dir, mode: mode};
               rem_d   = (mode == MODE_ROT) ? rot_amt : amount;
               state_d = (rem_d == '0) ? S_DONE : S_SHIFT;
`ifdef SEQ_SHIFT_OVF_EN
               ovf_d  = 1'b0;
               sign_d = din[WIDTH-1];
`endif
            end
         end
         S_SHIFT: begin
            dout_d = step_data;
            rem_d  = rem_q - AW'(k);
            if (rem_d == '0) state_d = S_DONE;
`ifdef SEQ_SHIFT_OVF_EN
            // Reserved mode behaves as logical; rotate and right shifts never overflow.
            if (cfg_q.dir == DIR_L && cfg_q.mode != MODE_ROT) begin
               if (cfg_q.mode == MODE_ARITH) begin
                  if (|((out_bits ^ {STEP{sign_q}}) & out_mask)) ovf_d = 1'b1;
                  if (rem_d == '0 && step_data[WIDTH-1] != sign_q) ovf_d = 1'b1;
               end else if (|(out_bits & out_mask)) begin
                  ovf_d = 1'b1;
               end
            end
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         dout_q  <= '0;
         cfg_q   <= '{dir: DIR_L, mode: MODE_LOGIC};
`ifdef SEQ_SHIFT_OVF_EN
         ovf_q  <= 1'b0;
         sign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dout_q  <= dout_d;
         cfg_q   <= cfg_d;
`ifdef SEQ_SHIFT_OVF_EN
         ovf_q  <= ovf_d;
         sign_q <= sign_d;
`endif
      end
   end

   assign busy    = (state_q == S_SHIFT);
   assign done    = (state_q == S_DONE);
   assign dout    = dout_q;
   assign state_o = state_q;
`ifdef SEQ_SHIFT_OVF_EN
   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit (WIDTH=8, STEP=2); checks ovf too when SEQ_SHIFT_OVF_EN is defined.
// Protocol: start is accepted on a rising edge while idle; done is a one-cycle pulse with dout final.
module tb_seq_shift_unit;
   import seq_shift_unit_pkg::*;

   localparam int W    = 8;
   localparam int STEP = 2;
   localparam int AW   = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  din = '0;
   logic [AW-1:0] amount = '0;
   logic          dir = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic          busy, done;
   logic [W-1:0]  dout;
   logic [1:0]    state_dbg;
`ifdef SEQ_SHIFT_OVF_EN
   logic          ovf;
`endif

   seq_shift_unit #(.WIDTH(W), .STEP(STEP)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .din     (din),
      .amount  (amount),
      .dir     (dir),
      .mode    (mode),
      .busy    (busy),
      .done    (done),
      .dout    (dout),
      .state_o (state_dbg)
`ifdef SEQ_SHIFT_OVF_EN
      ,
      .ovf     (ovf)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q[$];
   int     n_checks = 0;
   int     n_err    = 0;
   logic   m_valid  = 1'b0;
   int     m_t0     = 0;
   int     m_lat    = 0;
   logic   m_ovf    = 1'b0;
   logic [W-1:0] m_hold = '0;
   logic   m_ovf_hold = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [W-1:0] model_result(input logic [W-1:0] d, input int a,
                                                 input logic dr, input logic [1:0] md);
      logic [W-1:0] r;
      r = d;
      if (md == MODE_ROT) begin
         for (int i = 0; i < a % W; i++)
            r = (dr == DIR_L) ? {r[W-2:0], r[W-1]} : {r[0], r[W-1:1]};
      end else if (dr == DIR_R && md == MODE_ARITH) begin
         r = (a >= W) ? {W{d[W-1]}} : W'($signed(d) >>> a);
      end else if (dr == DIR_R) begin
         r = (a >= W) ? '0 : d >> a;
      end else begin
         r = (a >= W) ? '0 : d << a;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] d, input int a,
                                      input logic dr, input logic [1:0] md);
      logic [W-1:0] v;
      logic         o;
      if (dr == DIR_R || md == MODE_ROT) return 1'b0;
      v = d;
      o = 1'b0;
      for (int i = 0; i < a; i++) begin
         if (md == MODE_ARITH) o = o | (v[W-1] != d[W-1]);
         else                  o = o | v[W-1];
         v = v << 1;
      end
      if (md == MODE_ARITH) o = o | (v[W-1] != d[W-1]);
      return o;
   endfunction

   function automatic int model_lat(input int a, input logic [1:0] md);
      int rem;
      rem = (md == MODE_ROT) ? a % W : a;
      return 1 + (rem + STEP - 1) / STEP;
   endfunction

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_dout", dout, 0);
      end else if (m_valid && cyc == m_t0 + m_lat) begin
         check("done_pulse", done, 1);
         check("done_busy", busy, 0);
         if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
         end else begin
            m_hold = exp_q.pop_front();
            check("done_dout", dout, m_hold);
         end
         m_ovf_hold = m_ovf;
`ifdef SEQ_SHIFT_OVF_EN
         check("done_ovf", ovf, m_ovf);
`endif
         m_valid = 1'b0;
      end else if (m_valid && cyc > m_t0) begin
         check("shift_busy", busy, 1);
         check("shift_done", done, 0);
      end else begin
         check("idle_busy", busy, 0);
         check("idle_done", done, 0);
         check("idle_dout", dout, m_hold);
`ifdef SEQ_SHIFT_OVF_EN
         check("idle_ovf", ovf, m_ovf_hold);
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic [W-1:0] d, input logic [AW-1:0] a,
                        input logic dr, input logic [1:0] md);
      @(posedge clk); #1;
      start  = 1'b1;
      din    = d;
      amount = a;
      dir    = dr;
      mode   = md;
      exp_q.push_back(model_result(d, int'(a), dr, md));
      m_ovf   = model_ovf(d, int'(a), dr, md);
      m_lat   = model_lat(int'(a), md);
      m_t0    = cyc;
      m_valid = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      din    = W'($urandom);
      amount = AW'($urandom_range(0, 15));
      dir    = 1'($urandom_range(0, 1));
      mode   = 2'($urandom_range(0, 3));
   endtask

   // Runs one operation and pins the model with hand-computed dout, latency and ovf.
   task automatic run(input logic [W-1:0] d, input logic [AW-1:0] a, input logic dr,
                      input logic [1:0] md, input logic poke_busy,
                      input logic [W-1:0] lit_dout, input int lit_lat, input logic lit_ovf);
      int  t0;
      int  n;
      issue(d, a, dr, md);
      t0 = m_t0;
      n  = -1;
      if (poke_busy) begin
         start  = 1'b1;
         din    = 8'h00;
         amount = 4'd5;
         @(posedge clk); #1;
         start  = 1'b0;
      end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done) begin
            n = cyc - t0;
            break;
         end
      end
      check("lit_latency", n, lit_lat);
      check("lit_dout", dout, lit_dout);
`ifdef SEQ_SHIFT_OVF_EN
      check("lit_ovf", ovf, lit_ovf);
`else
      if (lit_ovf === 1'bx) check("lit_ovf_x", 0, 1);
`endif
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", state_dbg, S_IDLE);
      check("reset_dout", dout, 0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run(8'h3F, 4'd2,  DIR_L, MODE_LOGIC, 1'b0, 8'hFC, 2, 1'b0);
      run(8'h92, 4'd3,  DIR_R, MODE_ARITH, 1'b1, 8'hF2, 3, 1'b0);
      run(8'h92, 4'd9,  DIR_L, MODE_ROT,   1'b0, 8'h25, 2, 1'b0);
      run(8'h92, 4'd2,  DIR_L, MODE_LOGIC, 1'b0, 8'h48, 2, 1'b1);
      run(8'h92, 4'd8,  DIR_L, MODE_LOGIC, 1'b0, 8'h00, 5, 1'b1);
      run(8'h92, 4'd12, DIR_R, MODE_ARITH, 1'b0, 8'hFF, 7, 1'b0);
      run(8'hB4, 4'd3,  DIR_R, MODE_LOGIC, 1'b0, 8'h16, 3, 1'b0);
      run(8'h81, 4'd3,  DIR_R, MODE_ROT,   1'b0, 8'h30, 3, 1'b0);
      run(8'hC3, 4'd5,  DIR_L, 2'b11,      1'b0, 8'h60, 4, 1'b1);
      run(8'hE1, 4'd2,  DIR_L, MODE_ARITH, 1'b0, 8'h84, 2, 1'b0);
      run(8'h40, 4'd1,  DIR_L, MODE_ARITH, 1'b0, 8'h80, 2, 1'b1);
      run(8'h40, 4'd15, DIR_R, MODE_ARITH, 1'b0, 8'h00, 9, 1'b0);

      // Zero amount: done on the first edge; a start during that done cycle is dropped.
      issue(8'hA5, 4'd0, DIR_L, MODE_LOGIC);
      @(negedge clk);
      check("amt0_done", done, 1);
      check("amt0_dout", dout, 8'hA5);
      start  = 1'b1;
      din    = 8'h11;
      amount = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("ignored_start_busy", busy, 0);
         check("ignored_start_dout", dout, 8'hA5);
      end

      // Reset in the middle of a long shift aborts without a done pulse.
      issue(8'hFF, 4'd7, DIR_L, MODE_LOGIC);
      @(posedge clk); #1;
      rst = 1'b1;
      m_valid = 1'b0;
      exp_q.delete();
      m_hold = '0;
      m_ovf_hold = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_dout", dout, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      run(8'h3F, 4'd2, DIR_L, MODE_LOGIC, 1'b0, 8'hFC, 2, 1'b0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
      $fatal(1);
   end

endmodule
